// File: rtl/wb_leds_sequencer.sv
// ---------------------------------------------------------------------------
// wb_leds_sequencer
//
// Autonomous Wishbone master that periodically writes an LED pattern
// (off, chaser, ping-pong or blink) to a single LED register at LED_ADDR.
// Every TICK_DIV cycles one write is issued. The block handles ack, err,
// rty (with bounded reissue) and a response timeout, and keeps a sticky
// error flag for the system.
//
// Optional build macro: WB_LEDS_SEQUENCER_STATS_EN
//    When defined, adds saturating 16-bit counters of successful writes
//    (wr_cnt_o) and failed writes (fail_cnt_o), both cleared by err_clr_i.
//
// Ports:
//    clk_i        system clock
//    rst_n_i      asynchronous active-low reset
//    en_i         sequencer enable
//    mode_i       0 off, 1 chaser, 2 ping-pong, 3 blink
//    err_clr_i    clears err_o (and the stats counters when present)
//    m_adr_o      Wishbone address (LED_ADDR while strobing, else 0)
//    m_dat_o      Wishbone write data (zero-extended pattern)
//    m_sel_o      byte select (4'hF while strobing, else 0)
//    m_we_o       write enable (1 while strobing, else 0)
//    m_cyc_o      bus cycle
//    m_stb_o      strobe
//    m_ack_i      acknowledge
//    m_err_i      bus error
//    m_rty_i      retry
//    busy_o       transaction in flight (request or retry gap)
//    err_o        sticky error: bus error, timeout or retry exhaustion
//    pattern_o    last successfully written pattern
//    wr_cnt_o     (stats build only) successful write count
//    fail_cnt_o   (stats build only) failed write count
// ---------------------------------------------------------------------------
module wb_leds_sequencer #(
   parameter int          NUM_LEDS  = 8,
   parameter int          TICK_DIV  = 25000000,
   parameter logic [31:0] LED_ADDR  = 32'h0000_0000,
   parameter int          TIMEOUT   = 16,
   parameter int          RETRY_MAX = 3
) (
   input  logic                clk_i,
   input  logic                rst_n_i,
   input  logic                en_i,
   input  logic [1:0]          mode_i,
   input  logic                err_clr_i,
   output logic [31:0]         m_adr_o,
   output logic [31:0]         m_dat_o,
   output logic [3:0]          m_sel_o,
   output logic                m_we_o,
   output logic                m_cyc_o,
   output logic                m_stb_o,
   input  logic                m_ack_i,
   input  logic                m_err_i,
   input  logic                m_rty_i,
   output logic                busy_o,
   output logic                err_o,
   output logic [NUM_LEDS-1:0] pattern_o
`ifdef WB_LEDS_SEQUENCER_STATS_EN
   ,
   output logic [15:0]         wr_cnt_o,
   output logic [15:0]         fail_cnt_o
`endif
);

   localparam int TICK_W = $clog2(TICK_DIV);
   localparam int TMO_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam int RTY_W  = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_REQ,
      S_GAP
   } state_t;

   state_t              state_q;
   logic [NUM_LEDS-1:0] pat_q;
   logic [NUM_LEDS-1:0] led_q;
   logic                dir_q;
   logic [1:0]          mode_q;
   logic                cyc_q;
   logic                stb_q;
   logic                err_q;
   logic [TICK_W-1:0]   cnt_q;
   logic [TICK_W-1:0]   cnt_d;
   logic [TMO_W-1:0]    tmo_q;
   logic [RTY_W-1:0]    rty_q;

   logic                tick;
   logic [NUM_LEDS-1:0] pat_init;
   logic [NUM_LEDS-1:0] pat_adv;
   logic                dir_adv;
   logic                in_req;
   logic                rsp_err;
   logic                rsp_rty;
   logic                rsp_ack;
   logic                tmo_hit;
   logic                rty_out;
   logic                fail;
   logic [31:0]         dat_ext;

   // Free-running step divider. It is held at zero while disabled so the
   // first tick lands a full period after enable, and it keeps running
   // regardless of the FSM so ticks that arrive mid-transaction are lost.
   always_comb begin
      cnt_d = cnt_q + TICK_W'(1);
      if (!en_i || (cnt_q == TICK_W'(TICK_DIV - 1))) begin
         cnt_d = '0;
      end
   end

   assign tick = en_i && (cnt_q == TICK_W'(TICK_DIV - 1));

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Starting pattern for the requested mode, loaded on enable and on a
   // mode change seen while waiting for the next step.
   always_comb begin
      pat_init = '0;
      case (mode_i)
         2'd1, 2'd2: pat_init[0] = 1'b1;
         2'd3:       pat_init = '1;
         default:    pat_init = '0;
      endcase
   end

   // Next pattern after a successful write. dir_q = 1 means the ping-pong
   // dot is travelling toward the MSB; it bounces at either end. The
   // rotate is written as two shifts so a single-LED build needs no
   // special case.
   always_comb begin
      pat_adv = pat_q;
      dir_adv = dir_q;
      case (mode_q)
         2'd0: pat_adv = '0;
         2'd1: pat_adv = (pat_q << 1) | (pat_q >> (NUM_LEDS - 1));
         2'd2: begin
            if (NUM_LEDS > 1) begin
               if (dir_q) begin
                  if (pat_q[NUM_LEDS-1]) begin
                     pat_adv = pat_q >> 1;
                     dir_adv = 1'b0;
                  end else begin
                     pat_adv = pat_q << 1;
                  end
               end else begin
                  if (pat_q[0]) begin
                     pat_adv = pat_q << 1;
                     dir_adv = 1'b1;
                  end else begin
                     pat_adv = pat_q >> 1;
                  end
               end
            end
         end
         default: pat_adv = ~pat_q;
      endcase
   end

   // Response decoding with priority err > rty > ack. A timeout only
   // counts in a cycle with no response at all; the retry that exceeds
   // the budget is folded into the failure path.
   always_comb begin
      in_req  = (state_q == S_REQ);
      rsp_err = in_req && m_err_i;
      rsp_rty = in_req && !m_err_i && m_rty_i;
      rsp_ack = in_req && !m_err_i && !m_rty_i && m_ack_i;
      tmo_hit = in_req && !m_err_i && !m_rty_i && !m_ack_i &&
                (tmo_q == TMO_W'(TIMEOUT - 1));
      rty_out = rsp_rty && (rty_q == RTY_W'(RETRY_MAX));
      fail    = rsp_err || rty_out || tmo_hit;
   end

   // Main sequencer FSM. cyc/stb are registered and raised on the edge
   // that sees the tick. After any completion the FSM returns to WAIT,
   // which falls back to IDLE on its own if the enable was dropped
   // during the transaction.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= S_IDLE;
         pat_q   <= '0;
         led_q   <= '0;
         dir_q   <= 1'b1;
         mode_q  <= 2'd0;
         cyc_q   <= 1'b0;
         stb_q   <= 1'b0;
         err_q   <= 1'b0;
         tmo_q   <= '0;
         rty_q   <= '0;
      end else begin
         err_q <= fail || (err_q && !err_clr_i);
         case (state_q)
            S_IDLE: begin
               if (en_i) begin
                  pat_q   <= pat_init;
                  dir_q   <= 1'b1;
                  mode_q  <= mode_i;
                  state_q <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (!en_i) begin
                  state_q <= S_IDLE;
               end else begin
                  if (mode_i != mode_q) begin
                     pat_q  <= pat_init;
                     dir_q  <= 1'b1;
                     mode_q <= mode_i;
                  end
                  if (tick) begin
                     cyc_q   <= 1'b1;
                     stb_q   <= 1'b1;
                     tmo_q   <= '0;
                     rty_q   <= '0;
                     state_q <= S_REQ;
                  end
               end
            end
            S_REQ: begin
               if (fail) begin
                  cyc_q   <= 1'b0;
                  stb_q   <= 1'b0;
                  state_q <= S_WAIT;
               end else if (rsp_rty) begin
                  cyc_q   <= 1'b0;
                  stb_q   <= 1'b0;
                  rty_q   <= rty_q + RTY_W'(1);
                  state_q <= S_GAP;
               end else if (rsp_ack) begin
                  led_q   <= pat_q;
                  pat_q   <= pat_adv;
                  dir_q   <= dir_adv;
                  cyc_q   <= 1'b0;
                  stb_q   <= 1'b0;
                  state_q <= S_WAIT;
               end else begin
                  tmo_q <= tmo_q + TMO_W'(1);
               end
            end
            default: begin
               cyc_q   <= 1'b1;
               stb_q   <= 1'b1;
               tmo_q   <= '0;
               state_q <= S_REQ;
            end
         endcase
      end
   end

   // Bus fields are only meaningful while strobing and read as zero
   // otherwise.
   always_comb begin
      dat_ext                 = '0;
      dat_ext[NUM_LEDS-1:0]   = pat_q;
   end

   assign m_cyc_o   = cyc_q;
   assign m_stb_o   = stb_q;
   assign m_adr_o   = stb_q ? LED_ADDR : 32'h0;
   assign m_dat_o   = stb_q ? dat_ext : 32'h0;
   assign m_sel_o   = stb_q ? 4'hF : 4'h0;
   assign m_we_o    = stb_q;
   assign busy_o    = (state_q == S_REQ) || (state_q == S_GAP);
   assign err_o     = err_q;
   assign pattern_o = led_q;

`ifdef WB_LEDS_SEQUENCER_STATS_EN
   logic [15:0] wr_cnt_q;
   logic [15:0] fail_cnt_q;

   // Saturating write/failure statistics; a clear request takes
   // precedence over a same-cycle increment.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_cnt_q   <= '0;
         fail_cnt_q <= '0;
      end else if (err_clr_i) begin
         wr_cnt_q   <= '0;
         fail_cnt_q <= '0;
      end else begin
         if (rsp_ack && (wr_cnt_q != 16'hFFFF)) begin
            wr_cnt_q <= wr_cnt_q + 16'd1;
         end
         if (fail && (fail_cnt_q != 16'hFFFF)) begin
            fail_cnt_q <= fail_cnt_q + 16'd1;
         end
      end
   end

   assign wr_cnt_o   = wr_cnt_q;
   assign fail_cnt_o = fail_cnt_q;
`endif

endmodule

// File: tb/tb_wb_leds_sequencer.sv
// ---------------------------------------------------------------------------
// tb_wb_leds_sequencer
//
// Directed bench for wb_leds_sequencer with NUM_LEDS = 4, TICK_DIV = 4.
// A small Wishbone slave model answers one cycle after it sees stb, with
// a programmable number of leading retries followed by ack, err or
// silence. Each scenario task drives its stimulus and checks its own
// hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_wb_leds_sequencer;

   localparam int          NLEDS = 4;
   localparam logic [31:0] ADDR  = 32'h0000_1000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic [1:0]  mode;
   logic        errClr;
   logic [31:0] mAdr;
   logic [31:0] mDat;
   logic [3:0]  mSel;
   logic        mWe;
   logic        mCyc;
   logic        mStb;
   logic        mAck = 1'b0;
   logic        mErr = 1'b0;
   logic        mRty = 1'b0;
   logic        busy;
   logic        errOut;
   logic [NLEDS-1:0] pattern;
`ifdef WB_LEDS_SEQUENCER_STATS_EN
   logic [15:0] wrCnt;
   logic [15:0] failCnt;
`endif

   int nCompared   = 0;
   int nMismatched = 0;
   int cycNo       = 0;

   int rtyWant   = 0;
   int finalResp = 0;
   int rtyGiven  = 0;

   wb_leds_sequencer #(
      .NUM_LEDS (NLEDS),
      .TICK_DIV (4),
      .LED_ADDR (ADDR),
      .TIMEOUT  (16),
      .RETRY_MAX(3)
   ) dut (
      .clk_i     (clk),
      .rst_n_i   (rst_n),
      .en_i      (en),
      .mode_i    (mode),
      .err_clr_i (errClr),
      .m_adr_o   (mAdr),
      .m_dat_o   (mDat),
      .m_sel_o   (mSel),
      .m_we_o    (mWe),
      .m_cyc_o   (mCyc),
      .m_stb_o   (mStb),
      .m_ack_i   (mAck),
      .m_err_i   (mErr),
      .m_rty_i   (mRty),
      .busy_o    (busy),
      .err_o     (errOut),
      .pattern_o (pattern)
`ifdef WB_LEDS_SEQUENCER_STATS_EN
      ,
      .wr_cnt_o  (wrCnt),
      .fail_cnt_o(failCnt)
`endif
   );

   // 10 ns clock; outputs are sampled on the falling edge.
   always #5 clk = ~clk;

   // Cycle stamp used to measure write spacing.
   always @(posedge clk) cycNo <= cycNo + 1;

   // Slave model: one-cycle response to a fresh strobe. The first rtyWant
   // responses of a transaction are retries, then finalResp picks
   // 0 = ack, 1 = err, 2 = no response.
   always @(posedge clk) begin
      mAck <= 1'b0;
      mErr <= 1'b0;
      mRty <= 1'b0;
      if (!busy) rtyGiven <= 0;
      if (mStb && !mAck && !mErr && !mRty) begin
         if (rtyGiven < rtyWant) begin
            mRty     <= 1'b1;
            rtyGiven <= rtyGiven + 1;
         end else if (finalResp == 0) begin
            mAck <= 1'b1;
         end else if (finalResp == 1) begin
            mErr <= 1'b1;
         end
      end
   end

   // Global guard so a stuck DUT cannot hang the run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Clean restart: reset pulse with enable low and a fresh slave setup.
   task automatic restart(input logic [1:0] m);
      en        = 1'b0;
      errClr    = 1'b0;
      rtyWant   = 0;
      finalResp = 0;
      mode      = m;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // Waits (bounded) for an acknowledged write and captures its data.
   task automatic waitWrite(output logic [31:0] dat, output int at, output bit ok);
      ok  = 1'b0;
      dat = '0;
      at  = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (mStb && mAck) begin
            dat = mDat;
            at  = cycNo;
            ok  = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset;
      rst_n  = 1'b1;
      en     = 1'b0;
      mode   = 2'd0;
      errClr = 1'b0;
      #2 rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      nCompared++;
      if ({mCyc, mStb, mWe, busy, errOut} !== 5'b0) begin
         nMismatched++;
         $display("[TB] FAIL reset_ctrl: got %b want 00000", {mCyc, mStb, mWe, busy, errOut});
      end
      nCompared++;
      if ({mAdr, mDat, mSel} !== 68'h0) begin
         nMismatched++;
         $display("[TB] FAIL reset_bus: adr %h dat %h sel %h want all 0", mAdr, mDat, mSel);
      end
      nCompared++;
      if (pattern !== 4'h0) begin
         nMismatched++;
         $display("[TB] FAIL reset_pattern: got %h want 0", pattern);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_chaser;
      logic [3:0]  expSeq [5] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
      logic [31:0] dat;
      int          at;
      int          prevAt;
      bit          ok;
      restart(2'd1);
      en     = 1'b1;
      prevAt = 0;
      for (int i = 0; i < 5; i++) begin
         waitWrite(dat, at, ok);
         nCompared++;
         if (!ok || dat !== {28'h0, expSeq[i]}) begin
            nMismatched++;
            $display("[TB] FAIL chaser_dat[%0d]: got %h (seen %0d) want %h", i, dat, ok, expSeq[i]);
         end
         if (i == 0) begin
            nCompared++;
            if (mAdr !== ADDR || mSel !== 4'hF || mWe !== 1'b1) begin
               nMismatched++;
               $display("[TB] FAIL chaser_fields: adr %h sel %h we %b want %h f 1", mAdr, mSel, mWe, ADDR);
            end
         end else begin
            nCompared++;
            if (at - prevAt != 4) begin
               nMismatched++;
               $display("[TB] FAIL chaser_period[%0d]: got %0d cycles want 4", i, at - prevAt);
            end
         end
         prevAt = at;
         @(negedge clk);
         nCompared++;
         if (pattern !== expSeq[i]) begin
            nMismatched++;
            $display("[TB] FAIL chaser_pattern[%0d]: got %h want %h", i, pattern, expSeq[i]);
         end
      end
   endtask

   task automatic test_pingpong;
      logic [3:0]  expSeq [8] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h2};
      logic [31:0] dat;
      int          at;
      bit          ok;
      restart(2'd2);
      en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         waitWrite(dat, at, ok);
         nCompared++;
         if (!ok || dat !== {28'h0, expSeq[i]}) begin
            nMismatched++;
            $display("[TB] FAIL pingpong_dat[%0d]: got %h (seen %0d) want %h", i, dat, ok, expSeq[i]);
         end
      end
      @(negedge clk);
      nCompared++;
      if (pattern !== 4'h2) begin
         nMismatched++;
         $display("[TB] FAIL pingpong_pattern: got %h want 2", pattern);
      end
   endtask

   task automatic test_bus_error;
      logic [31:0] dat;
      int          at;
      bit          ok;
      bit          sawErr;
      logic [31:0] errDat;
      restart(2'd3);
      finalResp = 1;
      en        = 1'b1;
      sawErr    = 1'b0;
      errDat    = '0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (mStb && mErr) begin
            sawErr = 1'b1;
            errDat = mDat;
            break;
         end
      end
      finalResp = 0;
      nCompared++;
      if (!sawErr || errDat !== 32'hF) begin
         nMismatched++;
         $display("[TB] FAIL err_first_dat: got %h (seen %0d) want f", errDat, sawErr);
      end
      @(negedge clk);
      nCompared++;
      if (errOut !== 1'b1 || pattern !== 4'h0 || busy !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL err_status: err %b pattern %h busy %b want 1 0 0", errOut, pattern, busy);
      end
      waitWrite(dat, at, ok);
      nCompared++;
      if (!ok || dat !== 32'hF) begin
         nMismatched++;
         $display("[TB] FAIL err_rewrite_dat: got %h (seen %0d) want f", dat, ok);
      end
      @(negedge clk);
      nCompared++;
      if (pattern !== 4'hF || errOut !== 1'b1) begin
         nMismatched++;
         $display("[TB] FAIL err_sticky: pattern %h err %b want f 1", pattern, errOut);
      end
      errClr = 1'b1;
      @(negedge clk);
      errClr = 1'b0;
      nCompared++;
      if (errOut !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL err_clear: got %b want 0", errOut);
      end
   endtask

   task automatic test_timeout;
      logic [31:0] dat;
      int          at;
      bit          ok;
      int          hiCnt;
      restart(2'd1);
      finalResp = 2;
      en        = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (mStb) break;
      end
      hiCnt = 0;
      for (int i = 0; i < 40; i++) begin
         if (!mStb) break;
         hiCnt++;
         @(negedge clk);
      end
      nCompared++;
      if (hiCnt != 16) begin
         nMismatched++;
         $display("[TB] FAIL timeout_len: got %0d cycles want 16", hiCnt);
      end
      nCompared++;
      if (errOut !== 1'b1 || busy !== 1'b0 || mCyc !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL timeout_status: err %b busy %b cyc %b want 1 0 0", errOut, busy, mCyc);
      end
      finalResp = 0;
      waitWrite(dat, at, ok);
      nCompared++;
      if (!ok || dat !== 32'h1) begin
         nMismatched++;
         $display("[TB] FAIL timeout_next_dat: got %h (seen %0d) want 1", dat, ok);
      end
   endtask

   task automatic test_retry;
      logic [31:0] dat;
      int          at;
      bit          ok;
      int          rises;
      int          gaps;
      logic        prevStb;
      restart(2'd1);
      rtyWant = 4;
      en      = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (busy) break;
      end
      rises   = 0;
      gaps    = 0;
      prevStb = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (!busy) break;
         if (mStb && !prevStb) rises++;
         if (!mStb) gaps++;
         prevStb = mStb;
         @(negedge clk);
      end
      nCompared++;
      if (rises != 4 || gaps != 3) begin
         nMismatched++;
         $display("[TB] FAIL retry_shape: got %0d issues %0d gap cycles want 4 3", rises, gaps);
      end
      nCompared++;
      if (errOut !== 1'b1 || mStb !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL retry_exhaust: err %b stb %b want 1 0", errOut, mStb);
      end
      restart(2'd1);
      rtyWant = 1;
      en      = 1'b1;
      waitWrite(dat, at, ok);
      nCompared++;
      if (!ok || dat !== 32'h1) begin
         nMismatched++;
         $display("[TB] FAIL retry_then_ack_dat: got %h (seen %0d) want 1", dat, ok);
      end
      @(negedge clk);
      nCompared++;
      if (errOut !== 1'b0 || pattern !== 4'h1) begin
         nMismatched++;
         $display("[TB] FAIL retry_then_ack_status: err %b pattern %h want 0 1", errOut, pattern);
      end
   endtask

   task automatic test_reset_mid_req;
      logic [31:0] dat;
      int          at;
      bit          ok;
      restart(2'd1);
      en = 1'b1;
      waitWrite(dat, at, ok);
      finalResp = 2;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (mStb) break;
      end
      @(negedge clk);
      nCompared++;
      if (mStb !== 1'b1 || pattern !== 4'h1) begin
         nMismatched++;
         $display("[TB] FAIL rst_pre: stb %b pattern %h want 1 1", mStb, pattern);
      end
      rst_n = 1'b0;
      #1;
      nCompared++;
      if ({mCyc, mStb, busy} !== 3'b000 || pattern !== 4'h0) begin
         nMismatched++;
         $display("[TB] FAIL rst_mid_req: cyc/stb/busy %b pattern %h want 000 0", {mCyc, mStb, busy}, pattern);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_disable_mid_req;
      logic [31:0] dat;
      int          at;
      bit          ok;
      int          stbSeen;
      restart(2'd1);
      en = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (mStb) break;
      end
      en = 1'b0;
      waitWrite(dat, at, ok);
      nCompared++;
      if (!ok || dat !== 32'h1) begin
         nMismatched++;
         $display("[TB] FAIL disable_complete_dat: got %h (seen %0d) want 1", dat, ok);
      end
      @(negedge clk);
      nCompared++;
      if (pattern !== 4'h1) begin
         nMismatched++;
         $display("[TB] FAIL disable_pattern: got %h want 1", pattern);
      end
      stbSeen = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (mStb || busy) stbSeen++;
      end
      nCompared++;
      if (stbSeen != 0) begin
         nMismatched++;
         $display("[TB] FAIL disable_quiet: got %0d active cycles want 0", stbSeen);
      end
   endtask

   // Scenario sequence followed by the single summary line.
   initial begin
      $display("[TB] starting wb_leds_sequencer bench");
      test_reset();
      test_chaser();
      test_pingpong();
      test_bus_error();
      test_timeout();
      test_retry();
      test_reset_mid_req();
      test_disable_mid_req();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
